// File: rtl/elevator_pkg.sv
// Shared elevator definitions: floor-count defaults, dispatcher state encoding
// and the sweep-direction constants used by the car controller and display.
package elevator_pkg;

  localparam int NUM_FLOORS_DEF = 16;
  localparam int FLOOR_W_DEF    = 4;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    ISSUE  = 2'd2,
    WAIT   = 2'd3
  } disp_state_t;

endpackage

// File: rtl/floor_scan_picker.sv
// Combinational SCAN target selection: current floor first, then nearest call
// ahead in the sweep direction, else nearest call after reversing.
module floor_scan_picker
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = NUM_FLOORS_DEF,
  parameter int FLOOR_W    = FLOOR_W_DEF
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    car_floor,
  input  logic                  dir_up,
  output logic                  found,
  output logic [FLOOR_W-1:0]    pick_floor,
  output logic                  new_dir
);

  logic               here_hit;
  logic               up_found;
  logic               dn_found;
  logic [FLOOR_W-1:0] up_pick;
  logic [FLOOR_W-1:0] dn_pick;

  // Descending scan leaves the lowest bit above the car; ascending scan leaves
  // the highest bit below it. No index wrap-around at the edge floors.
  always_comb begin
    here_hit = 1'b0;
    up_found = 1'b0;
    up_pick  = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && (FLOOR_W'(i) == car_floor)) here_hit = 1'b1;
      if (pending[i] && (FLOOR_W'(i) > car_floor)) begin
        up_found = 1'b1;
        up_pick  = FLOOR_W'(i);
      end
    end
    dn_found = 1'b0;
    dn_pick  = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (FLOOR_W'(i) < car_floor)) begin
        dn_found = 1'b1;
        dn_pick  = FLOOR_W'(i);
      end
    end
  end

  always_comb begin
    found      = 1'b1;
    pick_floor = car_floor;
    new_dir    = dir_up;
    if (here_hit) begin
      pick_floor = car_floor;
    end else if (dir_up == DIR_UP && up_found) begin
      pick_floor = up_pick;
    end else if (dir_up == DIR_DOWN && dn_found) begin
      pick_floor = dn_pick;
    end else if (dir_up == DIR_UP && dn_found) begin
      pick_floor = dn_pick;
      new_dir    = DIR_DOWN;
    end else if (dir_up == DIR_DOWN && up_found) begin
      pick_floor = up_pick;
      new_dir    = DIR_UP;
    end else begin
      found = 1'b0;
    end
  end

endmodule

// File: rtl/floor_request_dispatcher.sv
// Floor call dispatcher: pending-call bitmap, SCAN target selection and a
// valid/ready target offer to the car. Optional re-targeting: DISPATCH_RETARGET_EN.
//
//   state  | meaning
//   IDLE   | no outstanding calls
//   SELECT | one cycle, SCAN pick from pending/car_floor/dir_up
//   ISSUE  | offering tgt_floor, held until tgt_ready
//   WAIT   | target accepted, waiting for arrival at tgt_floor
module floor_request_dispatcher
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = NUM_FLOORS_DEF,
  parameter int FLOOR_W    = FLOOR_W_DEF
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  call_valid,
  input  logic [FLOOR_W-1:0]    call_floor,
  output logic                  call_err,
  input  logic [FLOOR_W-1:0]    car_floor,
  input  logic                  car_arrived,
  output logic                  tgt_valid,
  output logic [FLOOR_W-1:0]    tgt_floor,
  input  logic                  tgt_ready,
  output logic                  dir_up,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  busy
);

  disp_state_t           state, state_nxt;
  logic [NUM_FLOORS-1:0] set_vec, clr_vec, pending_nxt;
  logic                  call_in_range;
  logic                  found, new_dir, retarget_hit;
  logic [FLOOR_W-1:0]    pick_floor;

  assign call_in_range = int'(call_floor) < NUM_FLOORS;

  // An arrival clears its floor in every state and beats a same-cycle call.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (call_valid && (call_floor == FLOOR_W'(i))) set_vec[i] = 1'b1;
      if (car_arrived && (car_floor == FLOOR_W'(i))) clr_vec[i] = 1'b1;
    end
  end

  assign pending_nxt = (pending | set_vec) & ~clr_vec;

  floor_scan_picker #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_picker (
    .pending    (pending),
    .car_floor  (car_floor),
    .dir_up     (dir_up),
    .found      (found),
    .pick_floor (pick_floor),
    .new_dir    (new_dir)
  );

`ifdef DISPATCH_RETARGET_EN
  logic [NUM_FLOORS-1:0] between;
  logic [FLOOR_W-1:0]    last_car_floor;
  logic                  retarget_used;

  always_comb begin
    between = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (dir_up == DIR_UP)
        between[i] = (FLOOR_W'(i) > car_floor) && (FLOOR_W'(i) < tgt_floor);
      else
        between[i] = (FLOOR_W'(i) < car_floor) && (FLOOR_W'(i) > tgt_floor);
    end
  end

  assign retarget_hit = (state == WAIT) && !retarget_used &&
                        (|(set_vec & ~clr_vec & ~pending & between));

  // One re-target per floor the car passes; re-armed when car_floor moves.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      retarget_used  <= 1'b0;
      last_car_floor <= '0;
    end else begin
      last_car_floor <= car_floor;
      if (retarget_hit)                    retarget_used <= 1'b1;
      else if (car_floor != last_car_floor) retarget_used <= 1'b0;
    end
  end
`else
  assign retarget_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pending != '0) state_nxt = SELECT;
      SELECT:  state_nxt = found ? ISSUE : IDLE;
      ISSUE:   if (tgt_ready) state_nxt = WAIT;
      WAIT:    if ((car_arrived && (car_floor == tgt_floor)) || retarget_hit)
                 state_nxt = SELECT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= IDLE;
      pending   <= '0;
      tgt_floor <= '0;
      dir_up    <= DIR_UP;
      call_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      pending  <= pending_nxt;
      call_err <= call_valid && !call_in_range;
      if (state == SELECT && found) begin
        tgt_floor <= pick_floor;
        dir_up    <= new_dir;
      end
    end
  end

  assign tgt_valid = (state == ISSUE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_floor_request_dispatcher.sv
// Directed bench for floor_request_dispatcher: a 16-floor and a 12-floor
// instance share stimulus; expected values are hand-computed per step.
module tb_floor_request_dispatcher;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        call_valid = 1'b0;
  logic [3:0]  call_floor = '0;
  logic [3:0]  car_floor = '0;
  logic        car_arrived = 1'b0;
  logic        tgt_ready = 1'b0;

  logic        call_err, tgt_valid, dir_up, busy;
  logic [3:0]  tgt_floor;
  logic [15:0] pending;

  logic        call_err12, tgt_valid12, dir_up12, busy12;
  logic [3:0]  tgt_floor12;
  logic [11:0] pending12;

  int checks = 0;
  int errors = 0;
  int xfer_count = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  floor_request_dispatcher #(.NUM_FLOORS(16), .FLOOR_W(4)) u_dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .call_valid(call_valid), .call_floor(call_floor),
    .call_err(call_err), .car_floor(car_floor), .car_arrived(car_arrived),
    .tgt_valid(tgt_valid), .tgt_floor(tgt_floor), .tgt_ready(tgt_ready),
    .dir_up(dir_up), .pending(pending), .busy(busy)
  );

  floor_request_dispatcher #(.NUM_FLOORS(12), .FLOOR_W(4)) u_dut12 (
    .CLOCK_50(CLOCK_50), .reset(reset), .call_valid(call_valid), .call_floor(call_floor),
    .call_err(call_err12), .car_floor(car_floor), .car_arrived(car_arrived),
    .tgt_valid(tgt_valid12), .tgt_floor(tgt_floor12), .tgt_ready(tgt_ready),
    .dir_up(dir_up12), .pending(pending12), .busy(busy12)
  );

  always @(posedge CLOCK_50) if (tgt_valid && tgt_ready) xfer_count <= xfer_count + 1;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic call(input logic [3:0] f);
    call_valid = 1'b1; call_floor = f;
    tick();
    call_valid = 1'b0;
  endtask

  task automatic arrive(input logic [3:0] f);
    car_floor = f; car_arrived = 1'b1;
    tick();
    car_arrived = 1'b0;
  endtask

  task automatic accept();
    tgt_ready = 1'b1;
    tick();
    tgt_ready = 1'b0;
  endtask

  initial begin
    tick(); tick();
    check("rst_pending", pending, 0);
    check("rst_tgt_valid", tgt_valid, 0);
    check("rst_tgt_floor", tgt_floor, 0);
    check("rst_dir_up", dir_up, 1);
    check("rst_call_err", call_err, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;

    // 1: call 5, car at 0 -> offer after two more edges
    call(4'd5);
    check("t1_pending", pending, 16'h0020);
    check("t1_n_valid", tgt_valid, 0);
    tick();
    check("t1_n1_valid", tgt_valid, 0);
    check("t1_n1_busy", busy, 1);
    tick();
    check("t1_n2_valid", tgt_valid, 1);
    check("t1_tgt_floor", tgt_floor, 5);
    check("t1_dir_up", dir_up, 1);

    // 2: backpressure then a single transfer
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t2_hold_valid", tgt_valid, 1);
      check("t2_hold_floor", tgt_floor, 5);
    end
    accept();
    check("t2_wait_valid", tgt_valid, 0);
    check("t2_wait_busy", busy, 1);
    arrive(4'd5);
    tick();
    check("t2_idle_busy", busy, 0);
    check("t2_idle_pending", pending, 0);
    check("t2_xfers", xfer_count, 1);

    // 3: car at 4 going up, pending {2,7}
    car_floor = 4'd4;
    call(4'd7);
    call(4'd2);
    tick();
    check("t3_valid", tgt_valid, 1);
    check("t3_floor7", tgt_floor, 7);
    check("t3_dir_up", dir_up, 1);
    check("t3_pending", pending, 16'h0084);
    accept();

    // 4: en-route service at 6 while waiting for 7
    car_floor = 4'd6;
    tick();
    call(4'd6);
    check("t4_pending_set", pending, 16'h00C4);
    arrive(4'd6);
    check("t4_pending_clr", pending, 16'h0084);
    tick(); tick();
    check("t4_still_wait_valid", tgt_valid, 0);
    check("t4_still_wait_busy", busy, 1);

    // 5: call and arrival at 6 in the same cycle -> clear wins
    call_valid = 1'b1; call_floor = 4'd6; car_arrived = 1'b1; car_floor = 4'd6;
    tick();
    call_valid = 1'b0; car_arrived = 1'b0;
    check("t5_pending", pending, 16'h0084);
    check("t5_valid", tgt_valid, 0);

    // 3 cont.: arrive 7 -> reverse and offer 2
    arrive(4'd7);
    check("t3_arr_pending", pending, 16'h0004);
    tick();
    check("t3_rev_valid", tgt_valid, 1);
    check("t3_rev_floor2", tgt_floor, 2);
    check("t3_rev_dir", dir_up, 0);
    accept();
    arrive(4'd2);
    tick();
    check("t3_idle_busy", busy, 0);

    // edge floor: car at 0 heading down, call 3 -> reversal, dir_up=1
    car_floor = 4'd0;
    call(4'd3);
    tick(); tick();
    check("edge_floor3", tgt_floor, 3);
    check("edge_dir", dir_up, 1);
    // arrival outside WAIT clears only that floor's bit
    call(4'd9);
    check("outwait_pending_set", pending, 16'h0208);
    arrive(4'd9);
    check("outwait_pending_clr", pending, 16'h0008);
    check("outwait_valid", tgt_valid, 1);
    check("outwait_floor", tgt_floor, 3);
    accept();
    arrive(4'd3);
    tick();
    check("edge_idle_busy", busy, 0);

    // 6: floor 15 on the 12-floor instance is rejected
    call(4'd15);
    check("t6_err12", call_err12, 1);
    check("t6_pending12", pending12, 0);
    check("t6_err16", call_err, 0);
    check("t6_pending16", pending, 16'h8000);
    tick();
    check("t6_err12_pulse", call_err12, 0);
    check("t6_busy12", busy12, 0);
    tick();
    check("t7_issue_valid", tgt_valid, 1);
    check("t7_issue_floor", tgt_floor, 15);

    // 7: reset during ISSUE
    reset = 1'b1;
    tick();
    check("t7_valid", tgt_valid, 0);
    check("t7_pending", pending, 0);
    check("t7_busy", busy, 0);
    check("t7_tgt_floor", tgt_floor, 0);
    reset = 1'b0;

    // 8: call between car and target while waiting
    car_floor = 4'd2;
    call(4'd9);
    tick(); tick();
    check("t8_floor9", tgt_floor, 9);
    accept();
    tick();
    call(4'd5);
`ifdef DISPATCH_RETARGET_EN
    tick();
    check("t8_retarget_valid", tgt_valid, 1);
    check("t8_retarget_floor", tgt_floor, 5);
`else
    tick();
    check("t8_no_retarget_valid", tgt_valid, 0);
    check("t8_no_retarget_floor", tgt_floor, 9);
`endif
    check("t8_pending", pending, 16'h0220);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
